// File: rtl/tm_infer_sequencer.sv
// Host-side sequencer for the convolutional Tsetlin-machine inference top:
// streams clause/weight words into the top, fires inference and captures the class.
//
// state     | meaning
// IDLE      | waiting for start / start_infer
// LD_CLAUSE | writing clause words 0..clauses-1
// LD_WEIGHT | writing weight words 0..CLASSN*WPC-1
// SETTLE    | last-write cycle, image reset, then a quiet cycle
// FIRE      | inference start pulse to the top
// WAIT      | waiting for done, bounded by TIMEOUT
module tm_infer_sequencer #(
    parameter int CLAUSEN = 10,
    parameter int CLASSN  = 10,
    parameter int WPC     = 5,
    parameter int TIMEOUT = 65535
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      start_infer,
    input  logic [8:0]                clauses_cfg,
    input  logic [255:0]              s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic [255:0]              clause_write,
    output logic [31:0]               bram_addr_a,
    output logic                      wea,
    output logic [255:0]              weight_write,
    output logic [31:0]               bram_addr_a2,
    output logic                      wea2,
    output logic                      img_rst,
    output logic                      done_rmu,
    output logic [8:0]                clauses,
    input  logic                      done,
    input  logic [$clog2(CLASSN)-1:0] class_op,
    output logic [$clog2(CLASSN)-1:0] result_class,
    output logic                      result_valid,
    output logic                      busy,
    output logic                      err
);

    localparam int NWEIGHT = CLASSN * WPC;

    typedef enum logic [2:0] {IDLE, LD_CLAUSE, LD_WEIGHT, SETTLE, FIRE, WAIT} state_t;

    state_t      state;
    logic [15:0] idx;
    logic [1:0]  settle_cnt;
    logic [16:0] wait_cnt;
    logic        model_loaded;
    logic        beat;

    assign beat = s_valid & s_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            settle_cnt   <= '0;
            wait_cnt     <= '0;
            model_loaded <= 1'b0;
            s_ready      <= 1'b0;
            clause_write <= '0;
            bram_addr_a  <= '0;
            wea          <= 1'b0;
            weight_write <= '0;
            bram_addr_a2 <= '0;
            wea2         <= 1'b0;
            img_rst      <= 1'b0;
            done_rmu     <= 1'b0;
            clauses      <= '0;
            result_class <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            wea      <= 1'b0;
            wea2     <= 1'b0;
            img_rst  <= 1'b0;
            done_rmu <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        result_valid <= 1'b0;
                        if (clauses_cfg == 9'd0 || int'(clauses_cfg) > CLAUSEN) begin
                            err <= 1'b1;
                        end else begin
                            err     <= 1'b0;
                            clauses <= clauses_cfg;
                            idx     <= '0;
                            s_ready <= 1'b1;
                            busy    <= 1'b1;
                            state   <= LD_CLAUSE;
                        end
                    end else if (start_infer) begin
                        if (model_loaded) begin
                            result_valid <= 1'b0;
                            err          <= 1'b0;
                            settle_cnt   <= '0;
                            busy         <= 1'b1;
                            state        <= SETTLE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LD_CLAUSE: begin
                    if (beat) begin
                        wea          <= 1'b1;
                        clause_write <= s_data;
                        bram_addr_a  <= 32'(idx);
                        if (idx + 16'd1 == 16'(clauses)) begin
                            idx   <= '0;
                            state <= LD_WEIGHT;
                        end else begin
                            idx <= idx + 16'd1;
                        end
                    end
                end
                LD_WEIGHT: begin
                    if (beat) begin
                        wea2         <= 1'b1;
                        weight_write <= s_data;
                        bram_addr_a2 <= 32'(idx);
                        if (idx == 16'(NWEIGHT - 1)) begin
                            s_ready      <= 1'b0;
                            model_loaded <= 1'b1;
                            settle_cnt   <= '0;
                            state        <= SETTLE;
                        end else begin
                            idx <= idx + 16'd1;
                        end
                    end
                end
                SETTLE: begin
                    // cycle 0 carries the final write strobe (or nothing on start_infer)
                    settle_cnt <= settle_cnt + 2'd1;
                    img_rst    <= (settle_cnt == 2'd0);
                    if (settle_cnt == 2'd2) begin
                        done_rmu <= 1'b1;
                        wait_cnt <= '0;
                        state    <= FIRE;
                    end
                end
                FIRE: begin
                    wait_cnt <= wait_cnt + 17'd1;
                    state    <= WAIT;
                end
                WAIT: begin
                    // counts below 3 are the first two WAIT cycles, where done may still be stale
                    if (done && wait_cnt >= 17'd3) begin
                        result_class <= class_op;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else if (wait_cnt + 17'd1 == 17'(TIMEOUT)) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 17'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tm_infer_sequencer.sv
// Bench for tm_infer_sequencer: vector table, random transactions against a
// transaction-level reference, and hand-written reset sequences.
module tb_tm_infer_sequencer;
    localparam int CLAUSEN = 10;
    localparam int CLASSN  = 10;
    localparam int WPC     = 5;
    localparam int TIMEOUT = 100;
    localparam int NW      = CLASSN * WPC;
    localparam int CW      = $clog2(CLASSN);
    localparam int NEVER   = 1000;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           start = 1'b0;
    logic           start_infer = 1'b0;
    logic [8:0]     clauses_cfg = '0;
    logic [255:0]   s_data = '0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [255:0]   clause_write;
    logic [31:0]    bram_addr_a;
    logic           wea;
    logic [255:0]   weight_write;
    logic [31:0]    bram_addr_a2;
    logic           wea2;
    logic           img_rst;
    logic           done_rmu;
    logic [8:0]     clauses;
    logic           done = 1'b0;
    logic [CW-1:0]  class_op = '0;
    logic [CW-1:0]  result_class;
    logic           result_valid;
    logic           busy;
    logic           err;

    tm_infer_sequencer #(
        .CLAUSEN(CLAUSEN), .CLASSN(CLASSN), .WPC(WPC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_infer(start_infer),
        .clauses_cfg(clauses_cfg), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .clause_write(clause_write), .bram_addr_a(bram_addr_a), .wea(wea),
        .weight_write(weight_write), .bram_addr_a2(bram_addr_a2), .wea2(wea2),
        .img_rst(img_rst), .done_rmu(done_rmu), .clauses(clauses), .done(done),
        .class_op(class_op), .result_class(result_class), .result_valid(result_valid),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // observed write traffic and pulse timestamps
    logic [255:0] cw_data[$];
    logic [255:0] ww_data[$];
    int cw_addr[$];
    int ww_addr[$];
    int last_ww_cyc, rmu_cyc, img_cyc, rmu_n, img_n, ready_n, busy_n;
    logic prev_sv = 1'b0;

    always @(negedge clk) begin
        if (wea) begin
            cw_data.push_back(clause_write);
            cw_addr.push_back(int'(bram_addr_a));
        end
        if (wea2) begin
            ww_data.push_back(weight_write);
            ww_addr.push_back(int'(bram_addr_a2));
            last_ww_cyc = cyc;
        end
        if (wea || wea2) check("write_follows_valid_beat", 64'(prev_sv), 64'd1);
        if (done_rmu) begin rmu_n++; rmu_cyc = cyc; end
        if (img_rst) begin img_n++; img_cyc = cyc; end
        if (s_ready) ready_n++;
        if (busy) busy_n++;
        prev_sv = s_valid;
    end

    bit loaded = 1'b0;
    bit last_valid = 1'b0;

    // Transaction-level reference: what one start/start_infer should produce.
    function automatic void ref_txn(input int mode, input int cfg, input bit ld, input bit pv,
                                    input int d, output bit e_err, output bit e_valid,
                                    output int e_nc, output int e_nw, output bit e_fire,
                                    output int e_lat);
        e_err = 0; e_valid = 0; e_nc = 0; e_nw = 0; e_fire = 0; e_lat = 0;
        if (mode != 1) begin
            if (cfg < 1 || cfg > CLAUSEN) begin e_err = 1; return; end
            e_nc = cfg;
            e_nw = NW;
        end else if (!ld) begin
            e_err = 1;
            e_valid = pv;
            return;
        end
        e_fire = 1;
        if (d <= TIMEOUT) begin
            e_valid = 1;
            e_lat = (d < 4) ? 4 : d;
        end else begin
            e_err = 1;
            e_lat = TIMEOUT;
        end
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_ctrl"}, 64'({s_ready, wea, wea2, img_rst, done_rmu, result_valid, busy, err,
                                   clauses, result_class}), 64'd0);
        check({tag, "_data"}, 64'(|{clause_write, weight_write, bram_addr_a, bram_addr_a2}), 64'd0);
    endtask

    // mode: 0 start, 1 start_infer, 2 both; gap: 0 none, 1 toggle, 2 random; d: done delay (0 = stale)
    task automatic run_txn(input int mode, input int cfg, input int gap, input int d,
                           input logic [CW-1:0] cls, input bit x_err, input bit x_valid);
        logic [255:0] words[$];
        bit e_err, e_valid, e_fire, acc, fin;
        int e_nc, e_nw, e_lat, s_cyc, end_cyc, b, guard, total, mism;
        ref_txn(mode, cfg, loaded, last_valid, d, e_err, e_valid, e_nc, e_nw, e_fire, e_lat);
        cw_data.delete(); ww_data.delete(); cw_addr.delete(); ww_addr.delete();
        rmu_n = 0; img_n = 0; ready_n = 0; busy_n = 0;
        total = e_nc + e_nw;
        for (int i = 0; i < total; i++)
            words.push_back({$urandom, $urandom, $urandom, $urandom,
                             $urandom, $urandom, $urandom, $urandom});
        @(posedge clk); #1;
        clauses_cfg = 9'(cfg);
        class_op = cls;
        done = (d == 0);
        start = (mode != 1);
        start_infer = (mode != 0);
        @(posedge clk); #1;
        s_cyc = cyc;
        start = 1'b0;
        start_infer = 1'b0;
        if (e_nc > 0) check("start_to_ready", 64'(s_ready), 64'd1);
        b = 0; guard = 0; fin = 0; end_cyc = -1;
        while (!fin && guard < 1000) begin
            if (end_cyc < 0 && !busy && (result_valid || err)) end_cyc = cyc;
            if (end_cyc >= 0 && guard >= 6) fin = 1;
            if (b < total) begin
                if (gap == 0) s_valid = 1'b1;
                else if (gap == 1) s_valid = (guard % 2 == 0);
                else s_valid = ($urandom_range(0, 1) == 1);
                s_data = words[b];
            end else begin
                s_valid = (total == 0 && guard < 6);
                s_data = '1;
            end
            if (d >= 1 && d <= 150 && rmu_n > 0 && cyc >= rmu_cyc + d - 1) done = 1'b1;
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            if (acc) b++;
            guard++;
        end
        s_valid = 1'b0;
        done = 1'b0;
        if (!fin) check("txn_completed", 64'd0, 64'd1);
        check("err", 64'(err), 64'(x_err));
        check("result_valid", 64'(result_valid), 64'(x_valid));
        if (x_valid && e_fire) check("result_class", 64'(result_class), 64'(cls));
        check("busy_at_end", 64'(busy), 64'd0);
        check("clause_write_count", 64'(cw_data.size()), 64'(e_nc));
        check("weight_write_count", 64'(ww_data.size()), 64'(e_nw));
        mism = 0;
        for (int i = 0; i < cw_data.size() && i < e_nc; i++)
            if (cw_addr[i] != i || cw_data[i] !== words[i]) mism++;
        for (int i = 0; i < ww_data.size() && i < e_nw; i++)
            if (ww_addr[i] != i || ww_data[i] !== words[e_nc + i]) mism++;
        check("write_addr_data_mismatches", 64'(mism), 64'd0);
        check("done_rmu_pulses", 64'(rmu_n), 64'(e_fire));
        check("img_rst_pulses", 64'(img_n), 64'(e_fire));
        if (e_fire && rmu_n == 1 && img_n == 1) begin
            if (e_nw > 0) check("last_weight_to_fire", 64'(rmu_cyc - last_ww_cyc), 64'd3);
            else check("infer_start_to_fire", 64'(rmu_cyc - s_cyc), 64'd3);
            check("img_rst_before_fire", 64'(rmu_cyc - img_cyc), 64'd2);
            check("fire_to_result", 64'(end_cyc - rmu_cyc), 64'(e_lat));
        end
        if (!e_fire) begin
            check("no_busy_when_rejected", 64'(busy_n), 64'd0);
            check("no_ready_when_rejected", 64'(ready_n), 64'd0);
        end
        if (e_nw == NW) loaded = 1'b1;
        last_valid = e_valid;
    endtask

    typedef struct {
        int            mode;
        int            cfg;
        int            gap;
        int            d;
        logic [CW-1:0] cls;
        bit            x_err;
        bit            x_valid;
    } vec_t;

    vec_t tbl[10];

    initial begin
        bit re, rv, rf;
        int rnc, rnw, rlat, mode, cfg, gap, d;
        logic [CW-1:0] cls;

        tbl[0] = '{1, 10, 0, 40,     CW'(5), 1'b1, 1'b0};
        tbl[1] = '{0, 10, 0, 40,     CW'(7), 1'b0, 1'b1};
        tbl[2] = '{0, 10, 1, 40,     CW'(3), 1'b0, 1'b1};
        tbl[3] = '{0, 0,  0, 40,     CW'(1), 1'b1, 1'b0};
        tbl[4] = '{0, 11, 0, 40,     CW'(1), 1'b1, 1'b0};
        tbl[5] = '{1, 0,  0, 40,     CW'(5), 1'b0, 1'b1};
        tbl[6] = '{0, 1,  0, NEVER,  CW'(2), 1'b1, 1'b0};
        tbl[7] = '{0, 4,  0, 0,      CW'(2), 1'b0, 1'b1};
        tbl[8] = '{2, 3,  0, 10,     CW'(9), 1'b0, 1'b1};
        tbl[9] = '{1, 0,  0, 2,      CW'(1), 1'b0, 1'b1};

        #2 rst_n = 1'b0;
        #1 check_reset("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (tbl[i])
            run_txn(tbl[i].mode, tbl[i].cfg, tbl[i].gap, tbl[i].d, tbl[i].cls,
                    tbl[i].x_err, tbl[i].x_valid);

        for (int n = 0; n < 40; n++) begin
            mode = ($urandom_range(0, 9) < 2) ? 1 : (($urandom_range(0, 9) == 0) ? 2 : 0);
            cfg = $urandom_range(0, 12);
            gap = $urandom_range(0, 2);
            case ($urandom_range(0, 3))
                0: d = 0;
                1: d = $urandom_range(4, 60);
                2: d = $urandom_range(90, 130);
                default: d = NEVER;
            endcase
            cls = CW'($urandom_range(0, CLASSN - 1));
            ref_txn(mode, cfg, loaded, last_valid, d, re, rv, rnc, rnw, rf, rlat);
            run_txn(mode, cfg, gap, d, cls, re, rv);
        end

        // reset in the middle of a clause load
        @(posedge clk); #1;
        clauses_cfg = 9'd10;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data = {8{32'(i)}};
            @(posedge clk); #1;
        end
        check("midload_wea_before_reset", 64'(wea), 64'd1);
        check("midload_addr_before_reset", 64'(bram_addr_a), 64'd4);
        rst_n = 1'b0;
        #1 check_reset("midload_reset");
        s_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        loaded = 1'b0;
        last_valid = 1'b0;
        run_txn(1, 0, 0, 40, CW'(4), 1'b1, 1'b0);
        run_txn(0, 10, 0, 40, CW'(7), 1'b0, 1'b1);
        run_txn(1, 0, 0, 20, CW'(8), 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
